// File: rtl/dut_pipe_if.sv
// Command/address/data bundle shared by the upstream and downstream sides of dut_pipe.
// The master drives the bundle and the slave samples it.
interface dut_if #(
  parameter int CMD_W  = 2,
  parameter int ADR_W  = 4,
  parameter int DATA_W = 3
);
  logic [CMD_W-1:0]  cmd;
  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] data;

  modport master (output cmd, output adr, output data);
  modport slave  (input  cmd, input  adr, input  data);
endinterface

// File: rtl/dut_pipe.sv
// Registered command pass-through with a 2**ADR_W-entry data store and a tracker
// that counts distinct addresses touched since reset.
module dut_pipe #(
  parameter int CMD_W  = 2,
  parameter int ADR_W  = 4,
  parameter int DATA_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  dut_if.slave           i_slave,
  dut_if.master          o_master,
  output logic           new_adr,
  output logic [ADR_W:0] uniq_cnt,
  output logic           all_seen
);
  localparam int DEPTH = 1 << ADR_W;

  localparam logic [CMD_W-1:0] CMD_NOP       = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_WRITE     = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_READ      = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_WRITE_FWD = CMD_W'(3);

  logic [DATA_W-1:0] r_store [DEPTH];
  logic [DEPTH-1:0]  r_seen;
  logic [CMD_W-1:0]  r_cmd;
  logic [ADR_W-1:0]  r_adr;
  logic [DATA_W-1:0] r_data;
  logic              r_new_adr;
  logic [ADR_W:0]    r_uniq_cnt;

  logic [CMD_W-1:0]  w_cmd;
  logic [ADR_W-1:0]  w_adr;
  logic [DATA_W-1:0] w_data;
  logic              w_write;
  logic              w_first_use;

  assign w_cmd  = i_slave.cmd;
  assign w_adr  = i_slave.adr;
  assign w_data = i_slave.data;

  assign w_write     = (w_cmd == CMD_WRITE) || (w_cmd == CMD_WRITE_FWD);
  assign w_first_use = (w_cmd != CMD_NOP) && !r_seen[w_adr];

  // Data store: writes land at the edge, so a READ on the next cycle sees them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_store[i] <= '0;
      end
    end else if (w_write) begin
      r_store[w_adr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd  <= '0;
      r_adr  <= '0;
      r_data <= '0;
    end else begin
      case (w_cmd)
        CMD_READ: begin
          r_cmd  <= CMD_READ;
          r_adr  <= w_adr;
          r_data <= r_store[w_adr];
        end
        CMD_WRITE_FWD: begin
          r_cmd  <= CMD_WRITE_FWD;
          r_adr  <= w_adr;
          r_data <= w_data;
        end
        default: begin
          r_cmd  <= '0;
          r_adr  <= '0;
          r_data <= '0;
        end
      endcase
    end
  end

  // Each address sets its bitmap bit once, which is what bounds uniq_cnt at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen     <= '0;
      r_new_adr  <= 1'b0;
      r_uniq_cnt <= '0;
    end else begin
      r_new_adr <= w_first_use;
      if (w_first_use) begin
        r_seen[w_adr] <= 1'b1;
        if (r_uniq_cnt != (ADR_W+1)'(DEPTH)) begin
          r_uniq_cnt <= r_uniq_cnt + (ADR_W+1)'(1);
        end
      end
    end
  end

  assign o_master.cmd  = r_cmd;
  assign o_master.adr  = r_adr;
  assign o_master.data = r_data;
  assign new_adr       = r_new_adr;
  assign uniq_cnt      = r_uniq_cnt;
  assign all_seen      = (r_uniq_cnt == (ADR_W+1)'(DEPTH));
endmodule

// File: tb/tb_dut_pipe.sv
// Randomised and directed checks of dut_pipe against a memory/set model of
// its command rules.
module tb_dut_pipe;
  localparam int CMD_W  = 2;
  localparam int ADR_W  = 4;
  localparam int DATA_W = 3;
  localparam int DEPTH  = 1 << ADR_W;

  logic           clk;
  logic           rst;
  logic           newAdr;
  logic [ADR_W:0] uniqCnt;
  logic           allSeen;

  dut_if #(.CMD_W(CMD_W), .ADR_W(ADR_W), .DATA_W(DATA_W)) slvIf ();
  dut_if #(.CMD_W(CMD_W), .ADR_W(ADR_W), .DATA_W(DATA_W)) mstIf ();

  dut_pipe #(.CMD_W(CMD_W), .ADR_W(ADR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_slave  (slvIf),
    .o_master (mstIf),
    .new_adr  (newAdr),
    .uniq_cnt (uniqCnt),
    .all_seen (allSeen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    vecCount  = 0;
  int    missCount = 0;
  string phase     = "init";

  // Model: contents of the store and the set of addresses touched since reset.
  int modelMem  [DEPTH];
  bit modelSeen [DEPTH];
  int expCmd, expAdr, expData, expNew, expCnt, expAll;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s/%s: observed %0d expected %0d", phase, tag,
               observed, expected);
    end
  endtask

  task automatic modelStep(input bit r, input int c, input int a, input int d);
    if (r) begin
      foreach (modelMem[i]) modelMem[i] = 0;
      foreach (modelSeen[i]) modelSeen[i] = 0;
      expCmd = 0; expAdr = 0; expData = 0; expNew = 0;
    end else begin
      expNew = (c != 0 && !modelSeen[a]) ? 1 : 0;
      if (c != 0) modelSeen[a] = 1;
      case (c)
        2: begin expCmd = 2; expAdr = a; expData = modelMem[a]; end
        3: begin expCmd = 3; expAdr = a; expData = d; end
        default: begin expCmd = 0; expAdr = 0; expData = 0; end
      endcase
      if (c == 1 || c == 3) modelMem[a] = d;
    end
    expCnt = 0;
    foreach (modelSeen[i]) expCnt += modelSeen[i];
    expAll = (expCnt == DEPTH) ? 1 : 0;
  endtask

  task automatic applyStimulus(input bit r, input int c, input int a, input int d);
    @(negedge clk);
    rst        = r;
    slvIf.cmd  = CMD_W'(c);
    slvIf.adr  = ADR_W'(a);
    slvIf.data = DATA_W'(d);
    @(posedge clk);
    modelStep(r, c, a, d);
    #1;
    checkOutput("cmd",  32'(mstIf.cmd),  32'(expCmd));
    checkOutput("adr",  32'(mstIf.adr),  32'(expAdr));
    checkOutput("data", 32'(mstIf.data), 32'(expData));
    checkOutput("new",  32'(newAdr),     32'(expNew));
    checkOutput("cnt",  32'(uniqCnt),    32'(expCnt));
    checkOutput("all",  32'(allSeen),    32'(expAll));
  endtask

  task automatic resetRandom();
    repeat (2) applyStimulus(1'b1, $urandom_range(3), $urandom_range(15), $urandom_range(7));
  endtask

  initial begin
    rst = 1'b1;
    slvIf.cmd = '0; slvIf.adr = '0; slvIf.data = '0;

    phase = "reset";
    resetRandom();
    checkOutput("cntZero", 32'(uniqCnt), 32'd0);

    phase = "directed";
    applyStimulus(1'b0, 3, 5, 6);
    checkOutput("fwdCmd",  32'(mstIf.cmd),  32'd3);
    checkOutput("fwdData", 32'(mstIf.data), 32'd6);
    checkOutput("fwdNew",  32'(newAdr),     32'd1);
    applyStimulus(1'b0, 3, 5, 2);
    checkOutput("repNew",  32'(newAdr),     32'd0);
    checkOutput("repCnt",  32'(uniqCnt),    32'd1);
    applyStimulus(1'b0, 2, 5, 0);
    checkOutput("rdData",  32'(mstIf.data), 32'd2);
    applyStimulus(1'b0, 1, 9, 7);
    checkOutput("wrCmd",   32'(mstIf.cmd),  32'd0);
    checkOutput("wrCnt",   32'(uniqCnt),    32'd2);
    applyStimulus(1'b0, 0, 3, 4);
    checkOutput("nopNew",  32'(newAdr),     32'd0);
    applyStimulus(1'b0, 2, 9, 0);
    checkOutput("rawData", 32'(mstIf.data), 32'd7);

    phase = "fwdRandom";
    resetRandom();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 3, $urandom_range(15, 5), $urandom_range(7));
      checkOutput("cntBound", 32'(uniqCnt > 11), 32'd0);
    end
    for (int a = 5; a < 16; a++) applyStimulus(1'b0, 3, a, $urandom_range(7));
    checkOutput("cntEleven", 32'(uniqCnt), 32'd11);

    phase = "mixed";
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, $urandom_range(3), $urandom_range(15), $urandom_range(7));
    end

    phase = "fullCover";
    resetRandom();
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 2, a, $urandom_range(7));
      checkOutput("rdZero", 32'(mstIf.data), 32'd0);
    end
    checkOutput("cntFull", 32'(uniqCnt), 32'd16);
    checkOutput("allSet",  32'(allSeen), 32'd1);
    applyStimulus(1'b0, 3, 0, 5);
    checkOutput("cntSat",  32'(uniqCnt), 32'd16);

    phase = "midReset";
    resetRandom();
    applyStimulus(1'b0, 2, 0, 0);
    checkOutput("lostData", 32'(mstIf.data), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
